mem_dump_reader: RTL and testbench
==================================

Name: mem_dump_reader

Overview:
- Readback engine for the 1024-word distributed data memory. It is the host-side read counterpart of the external load port that writes memory while the core is held.
- On a start command it walks a contiguous address range through the memory's asynchronous read port and streams each word, with its address, to the host over a valid/ready interface.
- It asserts core_hold for the whole dump so the processor cannot modify memory mid-transfer.

Parameters:
- ADDR_W, 10, memory word-address width (1024 words).
- DATA_W, 32, memory word width.
- CNT_W, 11, word-count width; must hold 0..2^ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle dump request; sampled only in IDLE.
- base_addr  input  ADDR_W  first word address; latched on accepted start.
- word_count  input  CNT_W  number of words to dump; latched on accepted start.
- mem_rd_addr  output  ADDR_W  address driven to the memory async read port (dpra).
- mem_rd_data  input  DATA_W  memory read data (dpo), valid combinationally in the same cycle.
- out_valid  output  1  out_data/out_addr hold a word for the host.
- out_ready  input  1  host accepts the word when out_valid && out_ready at a clock edge.
- out_data  output  DATA_W  dumped word.
- out_addr  output  ADDR_W  address of out_data.
- out_last  output  1  high with out_valid on the final word of the dump.
- busy  output  1  high from the cycle after an accepted start until the cycle after done.
- done  output  1  one-cycle pulse when the dump completes.
- core_hold  output  1  equals busy; the top level ORs it into the processor enable/stall.

Behaviour:
- Reset (synchronous, rst=1 at an edge): state=IDLE, out_valid=0, out_last=0, out_data=0, out_addr=0, mem_rd_addr=0, busy=0, done=0, core_hold=0, internal cur_addr=0, remaining=0. Reset overrides all other inputs, including mid-dump; any pending word is dropped without a handshake.
- FSM states: IDLE, FETCH, SEND, FINISH.
- IDLE:
  - start=1 with word_count!=0: latch cur_addr=base_addr and remaining=word_count, then go to FETCH.
  - start=1 with word_count==0: go to FINISH directly; no words are output.
  - start=0: stay in IDLE.
- FETCH (1 cycle):
  - mem_rd_addr=cur_addr combinationally.
  - At the edge: out_data<=mem_rd_data, out_addr<=cur_addr, out_valid<=1, out_last<=(remaining==1). Go to SEND.
- SEND:
  - out_valid, out_data, out_addr and out_last are held stable until the handshake.
  - On handshake: out_valid<=0, remaining<=remaining-1, cur_addr<=cur_addr+1 modulo 2^ADDR_W (1023 wraps to 0).
  - After the handshake, go to FINISH if remaining==1, otherwise to FETCH.
  - Without a handshake, stay in SEND indefinitely; there is no timeout.
- FINISH (1 cycle): done=1 and busy still 1. Next state is IDLE, where busy=0.
- Latency and throughput:
  - Accepted start to first out_valid: 2 cycles (IDLE->FETCH->SEND).
  - With out_ready held high: one word every 2 cycles.
  - A dump of N words takes 2N+1 cycles from the start edge to the done pulse.
- mem_rd_addr is driven to cur_addr in every state; it is 0 in IDLE after reset.
- start is ignored while busy; a start asserted in the FINISH cycle is ignored, and the block re-arms in IDLE.
- word_count greater than 2^ADDR_W is not clamped; addresses wrap and words repeat. Software must not request this.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Preload mem[5..8]=32'hA0..A3; start base=5, count=4, out_ready=1 -> four beats with (addr,data) = (5,A0),(6,A1),(7,A2),(8,A3) at 2-cycle spacing; out_last only on addr 8; done pulse 9 cycles after the start edge; busy/core_hold high throughout.
- Wrap: mem[1022]=1, mem[1023]=2, mem[0]=3; base=1022, count=3 -> addresses 1022,1023,0 with data 1,2,3; done pulse.
- Backpressure: count=2, out_ready low for 5 cycles on the first beat -> out_data/out_addr stable while stalled; second beat begins exactly 2 cycles after the handshake.
- count=0 start -> no out_valid; done pulses 1 cycle after start; busy high for exactly 1 cycle.
- Reset mid-dump: count=10, assert rst during the 3rd SEND -> next cycle out_valid=0, busy=0, done=0; a new start base=0, count=1 then works normally.
- start pulsed during SEND -> ignored; the latched base/count are unchanged and the beat count equals the original word_count.

Source files
------------

// File: rtl/mem_dump_reader.sv
// mem_dump_reader: host-side readback engine for the distributed data memory.
// Walks a contiguous address range through the async read port and streams
// (addr, data) beats over valid/ready, holding the core for the whole dump.
module mem_dump_reader #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              core_hold
);

   typedef enum logic [1:0] {IDLE, FETCH, SEND, FINISH} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
   logic [CNT_W-1:0]    remaining_q, remaining_d;
   logic                out_valid_q, out_valid_d;
   logic                out_last_q, out_last_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic [ADDR_W-1:0]   out_addr_q, out_addr_d;

   // Handshake on the output beat; only meaningful while a word is held.
   logic                hs;
   assign hs = out_valid_q && out_ready;

   // State and datapath registers; reset drops any pending beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
      end
   end

   // Next-state logic: one fetch cycle then wait in SEND for the host.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (word_count != '0) ? FETCH : FINISH;
         FETCH:   state_d = SEND;
         SEND:    if (hs) state_d = (remaining_q == CNT_W'(1)) ? FINISH : FETCH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath updates: latch the range on start, capture the word in FETCH,
   // advance address/count on each accepted beat.
   always_comb begin
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;
      case (state_q)
         IDLE: begin
            if (start && (word_count != '0)) begin
               cur_addr_d  = base_addr;
               remaining_d = word_count;
            end
         end
         FETCH: begin
            out_data_d  = mem_rd_data;
            out_addr_d  = cur_addr_q;
            out_valid_d = 1'b1;
            out_last_d  = (remaining_q == CNT_W'(1));
         end
         SEND: begin
            if (hs) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               remaining_d = remaining_q - CNT_W'(1);
               // Address wraps naturally at the top of memory.
               cur_addr_d  = cur_addr_q + ADDR_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Moore outputs decoded from state; the read port always follows cur_addr.
   always_comb begin
      busy        = (state_q != IDLE);
      done        = (state_q == FINISH);
      core_hold   = (state_q != IDLE);
      mem_rd_addr = cur_addr_q;
      out_valid   = out_valid_q;
      out_last    = out_last_q;
      out_data    = out_data_q;
      out_addr    = out_addr_q;
   end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: behavioural memory, scoreboard of expected beats.
module tb_mem_dump_reader;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 11;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst, start, out_ready;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid, out_last, busy, done, core_hold;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;

  logic [DATA_W-1:0] mem [1024];
  assign mem_rd_data = mem[mem_rd_addr];

  beat_t sb[$];
  int    hs_k[$];
  int    total = 0, bad = 0;
  int    since = 0, busy_low = 0, nbeats = 0;

  mem_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done),
    .core_hold(core_hold));

  always #5 clk = ~clk;

  // Scoreboard: a beat is accepted at the next posedge when valid&&ready&&!rst.
  always @(negedge clk) begin
    if (out_valid && out_ready && !rst) begin
      nbeats++;
      hs_k.push_back(since);
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected addr=%0d data=%h", out_addr, out_data);
      end else begin
        beat_t e;
        e = sb.pop_front();
        if (out_addr !== e.addr || out_data !== e.data || out_last !== e.last) begin
          bad++;
          $display("FAIL beat got addr=%0d data=%h last=%b exp addr=%0d data=%h last=%b",
                   out_addr, out_data, out_last, e.addr, e.data, e.last);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    since++;
    if (!busy) busy_low++;
  endtask

  task automatic do_start(input int b, input int n);
    base_addr = ADDR_W'(b); word_count = CNT_W'(n); start = 1'b1;
    since = 0; busy_low = 0; nbeats = 0; hs_k.delete();
    step();
    start = 1'b0;
  endtask

  task automatic push_range(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      beat_t e;
      e.addr = ADDR_W'(b + i);
      e.data = mem[(b + i) % 1024];
      e.last = (i == n - 1);
      sb.push_back(e);
    end
  endtask

  // Steps until done or the bound expires; since holds cycles from start edge.
  task automatic wait_done(input int maxc, output bit seen);
    while (!done && since < maxc) step();
    seen = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; word_count = '0;
    step(); step();
    rst = 1'b0;
    total++;
    if ({out_valid, out_last, busy, done, core_hold} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00000", {out_valid, out_last, busy, done, core_hold});
    end
    total++;
    if (out_data !== '0 || out_addr !== '0 || mem_rd_addr !== '0) begin
      bad++; $display("FAIL reset_data data=%h addr=%0d rd=%0d exp 0", out_data, out_addr, mem_rd_addr);
    end
  endtask

  task automatic test_basic();
    bit seen;
    for (int i = 0; i < 4; i++) mem[5 + i] = 32'hA0 + i;
    out_ready = 1'b1;
    push_range(5, 4);
    do_start(5, 4);
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL basic_fetch valid=%b busy=%b exp 0/1", out_valid, busy);
    end
    wait_done(30, seen);
    total++;
    if (!seen || since !== 9) begin
      bad++; $display("FAIL basic_done seen=%b cycles=%0d exp 9", seen, since);
    end
    total++;
    if (busy_low !== 0 || core_hold !== 1'b1) begin
      bad++; $display("FAIL basic_busy low_cycles=%0d hold=%b exp 0/1", busy_low, core_hold);
    end
    total++;
    if (hs_k.size() != 4 || hs_k[0] != 2 || hs_k[1] != 4 || hs_k[2] != 6 || hs_k[3] != 8) begin
      bad++; $display("FAIL basic_spacing beats=%0d exp 4 at cycles 2,4,6,8", hs_k.size());
    end
    step();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || sb.size() != 0) begin
      bad++; $display("FAIL basic_idle busy=%b done=%b left=%0d exp 0/0/0", busy, done, sb.size());
    end
  endtask

  task automatic test_wrap();
    bit seen;
    mem[1022] = 32'd1; mem[1023] = 32'd2; mem[0] = 32'd3;
    out_ready = 1'b1;
    push_range(1022, 3);
    do_start(1022, 3);
    wait_done(30, seen);
    total++;
    if (!seen || since !== 7 || nbeats !== 3 || sb.size() != 0) begin
      bad++; $display("FAIL wrap seen=%b cycles=%0d beats=%0d left=%0d exp 1/7/3/0",
                      seen, since, nbeats, sb.size());
    end
    step();
  endtask

  task automatic test_backpressure();
    bit seen;
    logic [DATA_W-1:0] d0;
    logic [ADDR_W-1:0] a0;
    int stable_bad = 0;
    mem[100] = 32'hDEAD_0100; mem[101] = 32'hBEEF_0101;
    out_ready = 1'b0;
    push_range(100, 2);
    do_start(100, 2);
    step();
    d0 = out_data; a0 = out_addr;
    total++;
    if (out_valid !== 1'b1 || a0 !== 10'd100 || d0 !== 32'hDEAD_0100) begin
      bad++; $display("FAIL bp_first valid=%b addr=%0d data=%h exp 1/100/dead0100", out_valid, a0, d0);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid !== 1'b1 || out_data !== d0 || out_addr !== a0) stable_bad++;
    end
    total++;
    if (stable_bad != 0) begin
      bad++; $display("FAIL bp_stable unstable_cycles=%0d exp 0", stable_bad);
    end
    out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_gap valid=%b exp 0", out_valid);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || out_addr !== 10'd101 || out_last !== 1'b1) begin
      bad++; $display("FAIL bp_second valid=%b addr=%0d last=%b exp 1/101/1", out_valid, out_addr, out_last);
    end
    wait_done(40, seen);
    total++;
    if (!seen || sb.size() != 0) begin
      bad++; $display("FAIL bp_done seen=%b left=%0d exp 1/0", seen, sb.size());
    end
    step();
  endtask

  task automatic test_zero_count();
    out_ready = 1'b1;
    do_start(16, 0);
    total++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL zero_finish done=%b busy=%b valid=%b exp 1/1/0", done, busy, out_valid);
    end
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || nbeats !== 0) begin
      bad++; $display("FAIL zero_idle done=%b busy=%b beats=%0d exp 0/0/0", done, busy, nbeats);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    out_ready = 1'b1;
    push_range(200, 10);
    do_start(200, 10);
    while (since < 6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL rstmid_state valid=%b busy=%b done=%b exp 0/0/0", out_valid, busy, done);
    end
    total++;
    if (sb.size() != 8) begin
      bad++; $display("FAIL rstmid_beats left=%0d exp 8", sb.size());
    end
    sb.delete();
    push_range(0, 1);
    do_start(0, 1);
    wait_done(20, seen);
    total++;
    if (!seen || since !== 3 || nbeats !== 1 || sb.size() != 0) begin
      bad++; $display("FAIL rstmid_restart seen=%b cycles=%0d beats=%0d exp 1/3/1", seen, since, nbeats);
    end
    step();
  endtask

  task automatic test_start_in_send();
    bit seen;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) mem[300 + i] = 32'h3000 + i;
    push_range(300, 3);
    do_start(300, 3);
    step();
    base_addr = 10'd500; word_count = 11'd7; start = 1'b1;
    step();
    start = 1'b0; out_ready = 1'b1;
    wait_done(40, seen);
    total++;
    if (!seen || nbeats !== 3 || sb.size() != 0) begin
      bad++; $display("FAIL start_ignored seen=%b beats=%0d left=%0d exp 1/3/0", seen, nbeats, sb.size());
    end
    step();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL start_rearm busy=%b exp 0", busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC000_0000 | i;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_count();
    test_reset_mid();
    test_start_in_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
